secded_pipe_decoder: RTL and testbench

- Parametrised, pipelined successor to the team's combinational 32-bit SECDED correction/detection block.
- Decodes a DATA_W-bit Hamming+overall-parity codeword and corrects single-bit errors in data or check bits; double errors are flagged and passed uncorrected.
- Uses valid/ready handshakes, saturating error counters and a first-error log.
- Sits between memory read data and the consumer; the log and counters feed a scrub/status register bank.

---
 rtl/secded_pipe_decoder_if.sv | 51 +++++
 rtl/secded_pipe_decoder.sv | 172 +++++++++++++++++
 tb/tb_secded_pipe_decoder.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/secded_pipe_decoder_if.sv
// Bus bundle for secded_pipe_decoder: input/output streams, counters and error log.
// master = producer/consumer side, slave = decoder side.
interface secded_pipe_decoder_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
);
  // Smallest r with 2^r >= DATA_W + r + 1.
  function automatic int chk_width(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 32; i++)
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  localparam int CHK_W = chk_width(DATA_W);
  localparam int PAR_W = CHK_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PAR_W-1:0]  in_parity;
  logic [TAG_W-1:0]  in_tag;
  logic              corr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PAR_W-1:0]  out_parity;
  logic [TAG_W-1:0]  out_tag;
  logic              out_single;
  logic              out_double;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;
  logic              clr_cnt;
  logic              log_valid;
  logic [TAG_W-1:0]  log_tag;
  logic [PAR_W-1:0]  log_syndrome;

  modport slave (
    input  in_valid, in_data, in_parity, in_tag, corr_en, out_ready, clr_cnt,
    output in_ready, out_valid, out_data, out_parity, out_tag, out_single, out_double,
           sec_cnt, ded_cnt, log_valid, log_tag, log_syndrome
  );

  modport master (
    output in_valid, in_data, in_parity, in_tag, corr_en, out_ready, clr_cnt,
    input  in_ready, out_valid, out_data, out_parity, out_tag, out_single, out_double,
           sec_cnt, ded_cnt, log_valid, log_tag, log_syndrome
  );
endinterface

// File: rtl/secded_pipe_decoder.sv
// Two-stage SECDED decoder: stage 1 computes syndrome/overall parity,
// stage 2 corrects and flags. Saturating error counters and a first-error log.
module secded_pipe_decoder #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst,
  secded_pipe_decoder_if.slave bus
);
  function automatic int chk_width(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 32; i++)
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    return r;
  endfunction

  localparam int          CHK_W  = chk_width(DATA_W);
  localparam int          PAR_W  = CHK_W + 1;
  localparam int          NPOS   = DATA_W + CHK_W;
  localparam logic [31:0] NPOS_W = 32'(NPOS);

  // Hamming position of data bit k: k-th non-power-of-two position.
  function automatic int data_pos(input int k);
    int cnt, pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= NPOS; p++)
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    return pos;
  endfunction

  logic [2:1]        vld_pipe;
  logic              adv2, ld1, ld2;

  logic [CHK_W-1:0]  syn_c;
  logic              ovr_c;

  logic [DATA_W-1:0] s1_data;
  logic [PAR_W-1:0]  s1_par;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_ce;
  logic [CHK_W-1:0]  s1_syn;
  logic              s1_ovr;

  logic [31:0]       syn_w;
  logic              dec_single, dec_double;
  logic [DATA_W-1:0] fix_data;
  logic [PAR_W-1:0]  fix_par;

  logic [DATA_W-1:0] o_data;
  logic [PAR_W-1:0]  o_par;
  logic [TAG_W-1:0]  o_tag;
  logic              o_single, o_double;
  logic [CNT_W-1:0]  sec_q, ded_q;
  logic              log_v;
  logic [TAG_W-1:0]  log_t;
  logic [PAR_W-1:0]  log_s;

  // Stage 2 moves when empty or drained; stage 1 moves when empty or stage 2 moves.
  assign adv2 = ~vld_pipe[2] | bus.out_ready;
  assign ld1  = ~vld_pipe[1] | adv2;
  assign ld2  = vld_pipe[1] & adv2;

  // Syndrome = received check bits XOR check bits recomputed from received data.
  always_comb begin
    syn_c = bus.in_parity[CHK_W-1:0];
    for (int k = 0; k < DATA_W; k++)
      syn_c ^= bus.in_data[k] ? CHK_W'(data_pos(k)) : '0;
    ovr_c = ^{bus.in_data, bus.in_parity};
  end

  // Classify the stage-1 word and build its corrected form.
  always_comb begin
    syn_w      = 32'(s1_syn);
    dec_single = s1_ovr & (syn_w <= NPOS_W);
    dec_double = (s1_ovr & (syn_w > NPOS_W)) | (~s1_ovr & (syn_w != 32'd0));
    fix_data   = s1_data;
    fix_par    = s1_par;
    if (s1_ce && dec_single) begin
      if (syn_w == 32'd0) fix_par[CHK_W] = ~fix_par[CHK_W];
      for (int i = 0; i < CHK_W; i++)
        if (syn_w == (32'd1 << i)) fix_par[i] = ~fix_par[i];
      for (int k = 0; k < DATA_W; k++)
        if (syn_w == 32'(data_pos(k))) fix_data[k] = ~fix_data[k];
    end
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_par   <= '0;
      s1_tag   <= '0;
      s1_ce    <= 1'b0;
      s1_syn   <= '0;
      s1_ovr   <= 1'b0;
      o_data   <= '0;
      o_par    <= '0;
      o_tag    <= '0;
      o_single <= 1'b0;
      o_double <= 1'b0;
    end else begin
      if (ld1) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_par  <= bus.in_parity;
          s1_tag  <= bus.in_tag;
          s1_ce   <= bus.corr_en;
          s1_syn  <= syn_c;
          s1_ovr  <= ovr_c;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          o_data   <= fix_data;
          o_par    <= fix_par;
          o_tag    <= s1_tag;
          o_single <= dec_single;
          o_double <= dec_double;
        end
      end
    end
  end

  // Saturating error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      sec_q <= '0;
      ded_q <= '0;
    end else if (ld2) begin
      if (dec_single && sec_q != '1) sec_q <= sec_q + 1'b1;
      if (dec_double && ded_q != '1) ded_q <= ded_q + 1'b1;
    end
  end

  // First-error log, sticky until cleared; clear beats a same-cycle capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_v <= 1'b0;
      log_t <= '0;
      log_s <= '0;
    end else if (bus.clr_cnt) begin
      log_v <= 1'b0;
    end else if (ld2 && (dec_single || dec_double) && !log_v) begin
      log_v <= 1'b1;
      log_t <= s1_tag;
      log_s <= {s1_ovr, s1_syn};
    end
  end

  assign bus.in_ready     = ld1;
  assign bus.out_valid    = vld_pipe[2];
  assign bus.out_data     = o_data;
  assign bus.out_parity   = o_par;
  assign bus.out_tag      = o_tag;
  assign bus.out_single   = o_single;
  assign bus.out_double   = o_double;
  assign bus.sec_cnt      = sec_q;
  assign bus.ded_cnt      = ded_q;
  assign bus.log_valid    = log_v;
  assign bus.log_tag      = log_t;
  assign bus.log_syndrome = log_s;
endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Self-checking bench: in-order scoreboard of behaviourally decoded words,
// checked every cycle, plus directed literal cases. A second decoder with
// 2-bit counters shares the stimulus to exercise saturation.
module tb_secded_pipe_decoder;
  localparam int DW = 32, CW = 6, PW = 7, TW = 4, NP = DW + CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  secded_pipe_decoder_if #(.DATA_W(DW), .TAG_W(TW), .CNT_W(16)) bus ();
  secded_pipe_decoder_if #(.DATA_W(DW), .TAG_W(TW), .CNT_W(2))  bus_s ();

  secded_pipe_decoder #(.DATA_W(DW), .TAG_W(TW), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  secded_pipe_decoder #(.DATA_W(DW), .TAG_W(TW), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_data   = bus.in_data;
  assign bus_s.in_parity = bus.in_parity;
  assign bus_s.in_tag    = bus.in_tag;
  assign bus_s.corr_en   = bus.corr_en;
  assign bus_s.out_ready = bus.out_ready;
  assign bus_s.clr_cnt   = bus.clr_cnt;

  typedef struct {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic [TW-1:0] tag;
    logic          s;
    logic          db;
    logic [PW-1:0] syn;
  } word_t;

  word_t         q[$];
  bit            head_s2;
  int            sec_n, ded_n;
  bit            logv;
  logic [TW-1:0] ltag;
  logic [PW-1:0] lsyn;
  int            n_tests = 0, n_fail = 0;

  function automatic bit is_pow2(int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  // Check bits for a clean codeword: low bits = XOR of positions of set data bits.
  function automatic logic [PW-1:0] encode(logic [DW-1:0] d);
    logic [31:0] s;
    int k;
    s = 0;
    k = 0;
    for (int pos = 1; pos <= NP; pos++)
      if (!is_pow2(pos)) begin
        if (d[k]) s = s ^ 32'(pos);
        k++;
      end
    return {^d ^ ^s[CW-1:0], s[CW-1:0]};
  endfunction

  // Reference decode: syndrome is the XOR of positions of all set codeword bits.
  function automatic word_t model_decode(logic [DW-1:0] d, logic [PW-1:0] p, logic [TW-1:0] tag, bit ce);
    word_t       w;
    logic [NP:1] cw;
    logic [31:0] s;
    bit          o;
    int          k, j;
    k = 0; j = 0; s = 0; o = p[CW];
    for (int pos = 1; pos <= NP; pos++)
      if (is_pow2(pos)) begin cw[pos] = p[j]; j++; end
      else begin cw[pos] = d[k]; k++; end
    for (int pos = 1; pos <= NP; pos++)
      if (cw[pos]) begin s = s ^ 32'(pos); o = !o; end
    w.tag = tag;
    w.syn = {o, s[CW-1:0]};
    w.s   = o && (s <= NP);
    w.db  = (o || s != 0) && !w.s;
    w.p   = p;
    w.d   = d;
    if (ce && w.s) begin
      if (s == 0) w.p[CW] = !w.p[CW];
      else cw[s] = !cw[s];
    end
    k = 0; j = 0;
    for (int pos = 1; pos <= NP; pos++)
      if (is_pow2(pos)) begin w.p[j] = cw[pos]; j++; end
      else begin w.d[k] = cw[pos]; k++; end
    return w;
  endfunction

  function automatic int sat(int n, int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  // Model: words in order; the oldest reaches the output one edge after it
  // is accepted or as soon as its predecessor leaves, whichever is later.
  always @(posedge clk) begin : model
    bit exp_ov, exp_ir;
    word_t w;
    if (rst) begin
      q.delete();
      head_s2 = 0; sec_n = 0; ded_n = 0; logv = 0; ltag = '0; lsyn = '0;
    end else begin
      exp_ov = (q.size() > 0) && head_s2;
      exp_ir = (q.size() < 2) || bus.out_ready;
      if (exp_ov && bus.out_ready) begin
        void'(q.pop_front());
        head_s2 = 0;
      end
      if (q.size() > 0 && !head_s2) begin
        head_s2 = 1;
        w = q[0];
        if (w.s) sec_n++;
        if (w.db) ded_n++;
        if ((w.s || w.db) && !logv) begin logv = 1; ltag = w.tag; lsyn = w.syn; end
      end
      if (bus.clr_cnt) begin sec_n = 0; ded_n = 0; logv = 0; end
      if (bus.in_valid && exp_ir)
        q.push_back(model_decode(bus.in_data, bus.in_parity, bus.in_tag, bus.corr_en));
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit exp_ov, exp_ir;
    if (rst) return;
    exp_ov = (q.size() > 0) && head_s2;
    exp_ir = (q.size() < 2) || bus.out_ready;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    chk("out_valid_sat", 64'(bus_s.out_valid), 64'(exp_ov));
    if (exp_ov) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].d));
      chk("out_parity", 64'(bus.out_parity), 64'(q[0].p));
      chk("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
      chk("out_single", 64'(bus.out_single), 64'(q[0].s));
      chk("out_double", 64'(bus.out_double), 64'(q[0].db));
    end
    chk("sec_cnt", 64'(bus.sec_cnt), 64'(sat(sec_n, 16)));
    chk("ded_cnt", 64'(bus.ded_cnt), 64'(sat(ded_n, 16)));
    chk("sec_cnt_sat", 64'(bus_s.sec_cnt), 64'(sat(sec_n, 2)));
    chk("ded_cnt_sat", 64'(bus_s.ded_cnt), 64'(sat(ded_n, 2)));
    chk("log_valid", 64'(bus.log_valid), 64'(logv));
    if (logv) begin
      chk("log_tag", 64'(bus.log_tag), 64'(ltag));
      chk("log_syndrome", 64'(bus.log_syndrome), 64'(lsyn));
    end
  endtask

  // Compare on the falling edge, then step past the next rising edge.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  // Present one word, let it be accepted, then let it reach the output.
  task automatic push(logic [DW-1:0] d, logic [PW-1:0] p, bit ce, logic [TW-1:0] tag);
    bus.in_valid = 1; bus.in_data = d; bus.in_parity = p; bus.corr_en = ce; bus.in_tag = tag;
    cycle();
    bus.in_valid = 0;
    cycle();
  endtask

  initial begin
    word_t       w;
    logic [38:0] v;
    int          sent, a, b;
    bit          acc, saw_drop;

    rst = 1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_parity = '0; bus.in_tag = '0;
    bus.corr_en = 1; bus.out_ready = 1; bus.clr_cnt = 0;
    repeat (2) cycle();
    rst = 0;

    // Reset state
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_sec_cnt", 64'(bus.sec_cnt), 64'd0);
    chk("rst_log_valid", 64'(bus.log_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);

    // Pin the reference model with hand-derived values
    w = model_decode(32'h1, 7'h00, 4'h0, 1);
    chk("model_d1", 64'(w.d), 64'd0);
    chk("model_syn1", 64'(w.syn), 64'b1000011);
    w = model_decode(32'h3, 7'h00, 4'h0, 1);
    chk("model_dbl", 64'({w.db, w.s}), 64'b10);
    w = model_decode(32'h1, 7'b1000010, 4'h0, 1);
    chk("model_p0", 64'(w.p), 64'b1000011);
    w = model_decode(32'h2, 7'b1000001, 4'h0, 1);
    chk("model_p2", 64'(w.p), 64'b1000101);
    chk("model_enc", 64'(encode(32'h1)), 64'b1000011);

    // Directed DUT cases
    push(32'h1, 7'h00, 1, 4'h1);
    chk("d1_single", 64'(bus.out_single), 64'd1);
    chk("d1_data", 64'(bus.out_data), 64'd0);
    chk("d1_sec", 64'(bus.sec_cnt), 64'd1);
    chk("d1_logsyn", 64'(bus.log_syndrome), 64'b1000011);
    push(32'h3, 7'h00, 1, 4'h2);
    chk("d2_double", 64'(bus.out_double), 64'd1);
    chk("d2_data", 64'(bus.out_data), 64'h3);
    chk("d2_ded", 64'(bus.ded_cnt), 64'd1);
    chk("d2_sec", 64'(bus.sec_cnt), 64'd1);
    push(32'h0, 7'b0000001, 1, 4'h3);
    chk("d3_parity", 64'(bus.out_parity), 64'd0);
    push(32'h1, 7'b1000010, 1, 4'h4);
    chk("d4_parity", 64'(bus.out_parity), 64'b1000011);
    push(32'h2, 7'b1000001, 1, 4'h5);
    chk("d5_parity", 64'(bus.out_parity), 64'b1000101);
    push(32'h1, 7'h00, 0, 4'h6);
    chk("d6_single", 64'(bus.out_single), 64'd1);
    chk("d6_data", 64'(bus.out_data), 64'h1);
    chk("d6_sec", 64'(bus.sec_cnt), 64'd5);
    chk("d6_sec_sat", 64'(bus_s.sec_cnt), 64'd3);

    // Clear in the same cycle as an error load: clear wins
    bus.in_valid = 1; bus.in_data = 32'h1; bus.in_parity = 7'h00; bus.corr_en = 1; bus.in_tag = 4'h7;
    cycle();
    bus.in_valid = 0; bus.clr_cnt = 1;
    cycle();
    bus.clr_cnt = 0;
    chk("clr_sec", 64'(bus.sec_cnt), 64'd0);
    chk("clr_log", 64'(bus.log_valid), 64'd0);
    chk("clr_single", 64'(bus.out_single), 64'd1);

    // Burst of 8 with a 3-cycle consumer stall
    sent = 0; saw_drop = 0;
    for (int i = 0; i < 60 && sent < 8; i++) begin
      bus.in_valid = 1;
      bus.in_data = $urandom;
      bus.in_parity = encode(bus.in_data) ^ (($urandom % 2 == 1) ? 7'h01 : 7'h00);
      bus.in_tag = 4'(sent);
      bus.out_ready = !(i >= 3 && i < 6);
      #1;
      acc = bus.in_ready;
      if (!acc) saw_drop = 1;
      cycle();
      if (acc) sent++;
    end
    if (sent < 8) chk("burst_timeout", 64'(sent), 64'd8);
    bus.in_valid = 0; bus.out_ready = 1;
    chk("burst_stall_drop", 64'(saw_drop), 64'd1);
    repeat (4) cycle();
    chk("burst_drained", 64'(bus.out_valid), 64'd0);

    // Reset while a word is in flight
    bus.in_valid = 1; bus.in_data = 32'h5; bus.in_parity = encode(32'h5);
    cycle();
    bus.in_valid = 0; rst = 1;
    cycle();
    rst = 0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);

    // Randomised traffic: clean words, single/double flips, garbage parity
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid = ($urandom % 10) < 7;
      bus.in_data = $urandom;
      v = {encode(bus.in_data), bus.in_data};
      case ($urandom % 4)
        1: v[$urandom % 39] ^= 1'b1;
        2: begin
          a = $urandom % 39;
          b = (a + 1 + ($urandom % 38)) % 39;
          v[a] ^= 1'b1;
          v[b] ^= 1'b1;
        end
        3: v[38:32] = 7'($urandom);
        default: ;
      endcase
      bus.in_parity = v[38:32];
      bus.in_data = v[31:0];
      bus.in_tag = 4'($urandom);
      bus.corr_en = ($urandom % 5) != 0;
      bus.out_ready = ($urandom % 10) < 7;
      bus.clr_cnt = ($urandom % 64) == 0;
      rst = ($urandom % 400) == 0;
      cycle();
    end
    rst = 0; bus.in_valid = 0; bus.clr_cnt = 0; bus.out_ready = 1;
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
